// File: rtl/oam_dma_pkg.sv
// Shared bus constants and DMA state type for the OAM DMA engine.
package oam_dma_pkg;

   localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
   localparam logic [15:0] OAM_BASE       = 16'hFE00;
   localparam int unsigned OAM_DMA_NBYTES = 160;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN
   } dma_state_t;

   // Writes of 0xE0..0xFF source from work RAM through the echo region.
   function automatic logic [7:0] fold_src_hi(input logic [7:0] v);
      return (v >= 8'hE0) ? v - 8'h20 : v;
   endfunction

endpackage

// File: rtl/dma_rd_pipe.sv
// RD_LAT-deep valid/index shift register tracking reads in flight; flush_i clears all valids.
module dma_rd_pipe #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              push_vld_i,
   input  logic [7:0]        push_idx_i,
   output logic [RD_LAT-1:0] vld_o,
   output logic [7:0]        exit_idx_o
);

   logic [RD_LAT-1:0] vld_q;
   logic [7:0]        idx_q [RD_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
      end else begin
         if (flush_i) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= push_vld_i;
            for (int unsigned i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
         end
         idx_q[0] <= push_idx_i;
         for (int unsigned i = 1; i < RD_LAT; i++) idx_q[i] <= idx_q[i-1];
      end
   end

   assign vld_o      = vld_q;
   assign exit_idx_o = idx_q[RD_LAT-1];

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: copies NBYTES from {src_hi,8'h00} into OAM through two mem_if master ports.
// Define OAM_DMA_PACED_EN to issue one byte per tick instead of one per clk.
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned NBYTES = OAM_DMA_NBYTES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        reg_we,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   output logic        busy,
   output logic [15:0] src_addr_select,
   output logic [7:0]  src_write_value,
   output logic        src_write_enable,
   input  logic [7:0]  src_read_out,
   output logic [7:0]  oam_addr_select,
   output logic [7:0]  oam_write_value,
   output logic        oam_write_enable,
   input  logic [7:0]  oam_read_out
);

   dma_state_t        state_q;
   logic [7:0]        idx_q;
   logic [7:0]        src_hi_q;
   logic [7:0]        reg_rdata_q;
   logic [15:0]       src_addr_q;
   logic [15:0]       src_addr_d;
   logic              busy_q;
   logic              slot;
   logic              issue;
   logic              pend;
   logic              exit_we;
   logic [RD_LAT-1:0] pipe_vld;
   logic [7:0]        exit_idx;
   logic              unused_oam_rd;

`ifdef OAM_DMA_PACED_EN
   assign slot = tick;
`else
   logic unused_tick;
   assign unused_tick = tick;
   assign slot        = 1'b1;
`endif

   assign unused_oam_rd = ^oam_read_out;

   // A restart write takes the cycle: no issue, and the exiting read is dropped.
   assign issue      = (state_q == XFER) && slot && !reg_we;
   assign src_addr_d = issue ? {src_hi_q, idx_q} : src_addr_q;
   assign exit_we    = pipe_vld[RD_LAT-1] && !reg_we;

   // Entries behind the exit stage keep the pipeline busy past this cycle.
   always_comb begin
      pend = 1'b0;
      for (int unsigned i = 0; i + 1 < RD_LAT; i++) pend = pend | pipe_vld[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         src_hi_q    <= '0;
         reg_rdata_q <= '0;
         src_addr_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         src_addr_q <= src_addr_d;
         if (reg_we) begin
            state_q     <= XFER;
            src_hi_q    <= fold_src_hi(reg_wdata);
            reg_rdata_q <= reg_wdata;
            idx_q       <= '0;
            busy_q      <= 1'b1;
         end else begin
            case (state_q)
               IDLE: busy_q <= 1'b0;
               XFER: begin
                  if (issue) begin
                     idx_q <= idx_q + 8'd1;
                     if (idx_q == 8'(NBYTES - 1)) state_q <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (!pend) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   dma_rd_pipe #(
      .RD_LAT(RD_LAT)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (reg_we),
      .push_vld_i(issue),
      .push_idx_i(idx_q),
      .vld_o     (pipe_vld),
      .exit_idx_o(exit_idx)
   );

   assign reg_rdata        = reg_rdata_q;
   assign busy             = busy_q;
   assign src_addr_select  = src_addr_d;
   assign src_write_value  = '0;
   assign src_write_enable = 1'b0;
   assign oam_write_enable = exit_we;
   assign oam_addr_select  = exit_we ? exit_idx : '0;
   assign oam_write_value  = exit_we ? src_read_out : '0;

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine: the initiating end of `mem_if`. A CPU write to the DMA register (0xFF46) makes it read 160 bytes from `{src_hi, 8'h00}` through a `mem_if` master port on the main bus and write them to OAM bytes 0x00–0x9F through a second `mem_if` master port. It sits between the bus decoder and the `bram_oam_m` CPU-side port. `busy` tells the decoder to lock out CPU accesses to everything except HRAM.

## Interface
- `RD_LAT`, default 1: read latency of the source `mem_if` slave, in clk cycles, from `addr_select` to valid `read_out`. Legal range 1–3.
- `NBYTES`, default 160: transfer length.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: M-cycle strobe, one clk wide. Used only when `OAM_DMA_PACED_EN` is defined.
- `reg_we` in 1: CPU write strobe for 0xFF46.
- `reg_wdata` in 8: source high byte.
- `reg_rdata` out 8: last value written to 0xFF46.
- `busy` out 1: transfer in progress.
- `src` `mem_if.master`:
  - drives `addr_select[15:0]` and `write_value`;
  - `write_enable` is held 0;
  - samples `read_out[7:0]`.
- `oam` `mem_if.master`:
  - drives `addr_select[7:0]`, `write_value[7:0]` and `write_enable`;
  - `read_out` is unused.

## Operation
- Source fold: if `reg_wdata >= 8'hE0`, the effective source high byte is `reg_wdata - 8'h20` (echo-RAM fold). `reg_rdata` still returns the unfolded written value.
- States:
  - IDLE: `busy` = 0.
  - XFER: issuing reads.
  - DRAIN: waiting for in-flight reads to return.
- IDLE → XFER on `reg_we`. `src_hi` and `reg_rdata` are latched from `reg_wdata` and `idx` is cleared to 0.
- XFER: on each issue slot, drive `src.addr_select = {src_hi, idx}` and push `(valid=1, idx)` into an `RD_LAT`-deep pipeline, then increment `idx`. After issuing `idx = NBYTES-1`, go to DRAIN.
  - Issue slot without the macro: every clk in XFER.
  - Issue slot with the macro: a clk where `tick` = 1.
- Pipeline exit with `valid` = 1: `oam.write_enable = 1`, `oam.addr_select = idx`, `oam.write_value = src.read_out`. These are driven combinationally in that cycle.
- DRAIN → IDLE when the pipeline holds no valid entries.
- `reg_we` in XFER or DRAIN (restart):
  - clear all pipeline valids and suppress any OAM write in that cycle;
  - reload `src_hi`, reset `idx` to 0, go to XFER;
  - bytes already written to OAM are not undone.
- `src.addr_select` holds its last value when not issuing. `oam.write_enable` = 0 except on pipeline exit.

## Timing
- Reset values:
  - `busy` 0, `reg_rdata` 8'h00;
  - `src.addr_select` 0, `oam.addr_select` 0, `oam.write_value` 0, `oam.write_enable` 0;
  - state IDLE, pipeline valids all 0.
- Fast mode, `reg_we` in cycle t:
  - `busy` = 1 from t+1;
  - issues in t+1 … t+NBYTES;
  - OAM write k in cycle t+1+k+RD_LAT;
  - `busy` = 0 in cycle t+NBYTES+RD_LAT+1.
- Paced mode:
  - the first issue is the first `tick` strictly after t;
  - the write follows its issue by exactly `RD_LAT` clks;
  - `tick` spacing is always at least `RD_LAT`+1 clks, so there is at most one read in flight.
- `busy` is registered (it changes on clk edges) and stays 1 through the final OAM write cycle.
- `rst_n` low mid-transfer: everything returns to the reset values immediately and asynchronously. No partial write occurs after reset is asserted.

## Configuration
- `OAM_DMA_PACED_EN` defined: one byte per `tick`, which gives hardware-accurate duration (160 M-cycles).
- `OAM_DMA_PACED_EN` undefined: `tick` is ignored and one byte is issued per clk.

## Structure
- The shared bus package holds:
  - `DMA_REG_ADDR = 16'hFF46`, `OAM_BASE = 16'hFE00`, `OAM_DMA_NBYTES = 160`;
  - a `dma_state_t` enum {IDLE, XFER, DRAIN}.
- Sub-module `dma_rd_pipe`: a parameterised `RD_LAT`-deep valid/index shift register with a synchronous flush input.

## Test plan
- Fast, RD_LAT=1, write 0xC1:
  - src addresses 0xC100–0xC19F in consecutive cycles;
  - OAM[k] = mem[0xC100+k] for all k;
  - `busy` high for exactly 161 cycles.
- Write 0xE3: reads come from 0xC300–0xC39F, and `reg_rdata` = 0xE3.
- Restart: write 0xC0, then write 0xD0 after 50 bytes.
  - no OAM write in the restart cycle;
  - OAM ends as 160 bytes from 0xD000;
  - `busy` stays high continuously.
- Paced with `tick` every 4 clks, RD_LAT=2:
  - each write occurs 2 clks after its issue;
  - transfer spans 160 ticks;
  - `busy` drops 3 clks after the last tick.
- `rst_n` pulsed low at byte 80:
  - all outputs 0 during reset;
  - no further OAM writes;
  - OAM[80..159] unchanged.
- RD_LAT=3, fast mode: last write at t+163, and `busy` drops at t+164.
